// File: rtl/vote_ctrl.sv
// ---------------------------------------------------------------------------
// vote_ctrl
//
// Purpose:
//   Session controller for the voting terminal. It opens a timed voting
//   window when start is pressed and accepts exactly one vote per voter. It
//   keeps the agree/disagree tallies as single BCD digits for the
//   seven-segment driver and reports passed/rejected once the session closes.
//   A session closes when the window timer runs out, or one cycle after every
//   voter has voted.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   start         session start key (debounced level)
//   abort         session abort key (debounced level)
//   vote_yes      per-voter agree keys (debounced levels)
//   vote_no       per-voter disagree keys (debounced levels)
//   agree         agree tally, BCD digit 0..9
//   disagree      disagree tally, BCD digit 0..9
//   voted         per-voter "vote recorded" flags
//   state         0 = IDLE, 1 = VOTING, 2 = RESULT
//   result_valid  high while in RESULT
//   passed        high in RESULT when agree > disagree
// ---------------------------------------------------------------------------
module vote_ctrl #(
  parameter int N_VOTERS      = 8,
  parameter int WINDOW_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N_VOTERS-1:0] vote_yes,
  input  logic [N_VOTERS-1:0] vote_no,
  output logic [3:0]          agree,
  output logic [3:0]          disagree,
  output logic [N_VOTERS-1:0] voted,
  output logic [1:0]          state,
  output logic                result_valid,
  output logic                passed
);

  // The timer only ever has to reach WINDOW_CYCLES-1, so clog2 bits suffice.
  localparam int TIMER_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [N_VOTERS-1:0] ALL_VOTED  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VOTING = 2'd1,
    S_RESULT = 2'd2,
    S_UNUSED = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           agree_q, agree_d;
  logic [3:0]           disagree_q, disagree_d;
  logic [N_VOTERS-1:0]  voted_q, voted_d;

  // Previous samples of every key, used for rising-edge detection.
  logic                 start_prev, abort_prev;
  logic [N_VOTERS-1:0]  yes_prev, no_prev;

  logic                 start_ev, abort_ev;
  logic [N_VOTERS-1:0]  yes_ev, no_ev;
  logic [N_VOTERS-1:0]  accept_yes, accept_no;

  // Number of set bits. N_VOTERS is at most 9, so four bits always hold it.
  function automatic logic [3:0] popcount(input logic [N_VOTERS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // BCD-digit add that saturates at 9. This is a safety net only, because a
  // legal N_VOTERS can never push a tally past 9.
  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 5'd9) ? 4'd9 : s[3:0];
  endfunction

  // A key produces an event only on the cycle it goes from low to high.
  // Holding a key down therefore yields a single event.
  assign start_ev = start & ~start_prev;
  assign abort_ev = abort & ~abort_prev;
  assign yes_ev   = vote_yes & ~yes_prev;
  assign no_ev    = vote_no  & ~no_prev;

  // A vote counts only for a voter who has not voted yet, and only if the
  // opposite key is not also down. Pressing both keys together is rejected,
  // and the voter keeps the right to try again.
  assign accept_yes = yes_ev & ~vote_no  & ~voted_q;
  assign accept_no  = no_ev  & ~vote_yes & ~voted_q;

  // State, timer, tallies and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      agree_q    <= '0;
      disagree_q <= '0;
      voted_q    <= '0;
      start_prev <= 1'b0;
      abort_prev <= 1'b0;
      yes_prev   <= '0;
      no_prev    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      agree_q    <= agree_d;
      disagree_q <= disagree_d;
      voted_q    <= voted_d;
      start_prev <= start;
      abort_prev <= abort;
      yes_prev   <= vote_yes;
      no_prev    <= vote_no;
    end
  end

  // Session sequencing. Each transition that starts or discards a session
  // also clears the timer, the tallies and the voted flags on the same edge.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    agree_d    = agree_q;
    disagree_d = disagree_q;
    voted_d    = voted_q;

    case (state_q)
      S_IDLE: begin
        if (start_ev && !abort_ev) begin
          state_d    = S_VOTING;
          timer_d    = '0;
          agree_d    = '0;
          disagree_d = '0;
          voted_d    = '0;
        end
      end

      S_VOTING: begin
        // Abort beats both votes and timer expiry. Any votes in this cycle
        // are discarded along with the rest of the session.
        if (abort_ev) begin
          state_d    = S_IDLE;
          timer_d    = '0;
          agree_d    = '0;
          disagree_d = '0;
          voted_d    = '0;
        end else if (voted_q == ALL_VOTED) begin
          // Everyone voted on the previous edge, so close early.
          state_d = S_RESULT;
          timer_d = '0;
        end else begin
          agree_d    = sat_add(agree_q, popcount(accept_yes));
          disagree_d = sat_add(disagree_q, popcount(accept_no));
          voted_d    = voted_q | accept_yes | accept_no;
          // Votes taken on the expiry edge are still counted above.
          if (timer_q == TIMER_LAST) begin
            state_d = S_RESULT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end

      S_RESULT: begin
        // Tallies stay frozen here. Abort wins over a simultaneous start.
        if (abort_ev) begin
          state_d    = S_IDLE;
          agree_d    = '0;
          disagree_d = '0;
          voted_d    = '0;
        end else if (start_ev) begin
          state_d    = S_VOTING;
          timer_d    = '0;
          agree_d    = '0;
          disagree_d = '0;
          voted_d    = '0;
        end
      end

      default: begin
        // The unused encoding falls back to a clean IDLE.
        state_d    = S_IDLE;
        timer_d    = '0;
        agree_d    = '0;
        disagree_d = '0;
        voted_d    = '0;
      end
    endcase
  end

  assign agree        = agree_q;
  assign disagree     = disagree_q;
  assign voted        = voted_q;
  assign state        = state_q;
  assign result_valid = (state_q == S_RESULT);
  assign passed       = (state_q == S_RESULT) && (agree_q > disagree_q);

endmodule

// File: tb/tb_vote_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vote_ctrl
//
// Purpose:
//   Self-checking bench for vote_ctrl with N_VOTERS=4 and WINDOW_CYCLES=20.
//   It has three parts:
//     - a vector table for the single-vote and held-key rules;
//     - hand-written sequences for timed close, a vote on the expiry edge,
//       abort at expiry, a tie, abort versus start, and asynchronous reset;
//     - random stimulus compared against a session-level reference model.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_vote_ctrl;

  localparam int NV  = 4;
  localparam int WIN = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [NV-1:0] vote_yes, vote_no;
  logic [3:0]    agree, disagree;
  logic [NV-1:0] voted;
  logic [1:0]    state;
  logic          result_valid, passed;

  int checks   = 0;
  int failures = 0;

  vote_ctrl #(.N_VOTERS(NV), .WINDOW_CYCLES(WIN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .vote_yes     (vote_yes),
    .vote_no      (vote_no),
    .agree        (agree),
    .disagree     (disagree),
    .voted        (voted),
    .state        (state),
    .result_valid (result_valid),
    .passed       (passed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic          a;
    logic [NV-1:0] y;
    logic [NV-1:0] n;
    logic [1:0]    st;
    logic [3:0]    ag;
    logic [3:0]    dg;
    logic [NV-1:0] vt;
    logic          rv;
    logic          ps;
  } vec_t;

  vec_t vecs[16];

  // Session-level reference model, kept as plain integers and per-voter
  // flags.
  int m_phase, m_timer, m_agree, m_disagree;
  bit m_voted[NV];
  bit p_start, p_abort;
  bit p_yes[NV], p_no[NV];

  function automatic vec_t mk(input logic s, input logic a,
                              input logic [NV-1:0] y, input logic [NV-1:0] n,
                              input logic [1:0] st, input logic [3:0] ag,
                              input logic [3:0] dg, input logic [NV-1:0] vt,
                              input logic rv, input logic ps);
    vec_t v;
    v.s = s; v.a = a; v.y = y; v.n = n;
    v.st = st; v.ag = ag; v.dg = dg; v.vt = vt; v.rv = rv; v.ps = ps;
    return v;
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [1:0] st,
                              input logic [3:0] ag, input logic [3:0] dg,
                              input logic [NV-1:0] vt, input logic rv, input logic ps);
    check_val({name, " state"}, 32'(state), 32'(st));
    check_val({name, " agree"}, 32'(agree), 32'(ag));
    check_val({name, " disagree"}, 32'(disagree), 32'(dg));
    check_val({name, " voted"}, 32'(voted), 32'(vt));
    check_val({name, " result_valid"}, 32'(result_valid), 32'(rv));
    check_val({name, " passed"}, 32'(passed), 32'(ps));
  endtask

  // Drive one cycle of inputs, let one active edge pass, and return 1 ns
  // later so outputs are sampled away from the edge.
  task automatic apply_stimulus(input logic s, input logic a,
                                input logic [NV-1:0] y, input logic [NV-1:0] n);
    start    = s;
    abort    = a;
    vote_yes = y;
    vote_no  = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; abort = 1'b0; vote_yes = '0; vote_no = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_clear();
    m_agree = 0;
    m_disagree = 0;
    m_timer = 0;
    for (int i = 0; i < NV; i++) m_voted[i] = 1'b0;
  endtask

  task automatic model_init();
    m_phase = 0;
    model_clear();
    p_start = 1'b0;
    p_abort = 1'b0;
    for (int i = 0; i < NV; i++) begin
      p_yes[i] = 1'b0;
      p_no[i] = 1'b0;
    end
  endtask

  // One clock edge of the voting rules: each voter gets one accepted vote
  // per session, the window lasts WIN edges, and the session closes early
  // once everyone has voted.
  task automatic model_edge(input logic s, input logic a,
                            input logic [NV-1:0] y, input logic [NV-1:0] n);
    bit s_ev, a_ev, ye, ne;
    int n_voted;
    s_ev = s && !p_start;
    a_ev = a && !p_abort;
    n_voted = 0;
    for (int i = 0; i < NV; i++) if (m_voted[i]) n_voted++;

    if (m_phase == 1) begin
      if (a_ev) begin
        m_phase = 0;
        model_clear();
      end else if (n_voted == NV) begin
        m_phase = 2;
        m_timer = 0;
      end else begin
        for (int i = 0; i < NV; i++) begin
          ye = y[i] && !p_yes[i];
          ne = n[i] && !p_no[i];
          if (!m_voted[i]) begin
            if (ye && !n[i]) begin
              m_agree++;
              m_voted[i] = 1'b1;
            end else if (ne && !y[i]) begin
              m_disagree++;
              m_voted[i] = 1'b1;
            end
          end
        end
        if (m_agree > 9) m_agree = 9;
        if (m_disagree > 9) m_disagree = 9;
        if (m_timer == WIN - 1) begin
          m_phase = 2;
          m_timer = 0;
        end else begin
          m_timer++;
        end
      end
    end else if (m_phase == 2) begin
      if (a_ev) begin
        m_phase = 0;
        model_clear();
      end else if (s_ev) begin
        m_phase = 1;
        model_clear();
      end
    end else begin
      if (s_ev && !a_ev) begin
        m_phase = 1;
        model_clear();
      end
    end

    p_start = s;
    p_abort = a;
    for (int i = 0; i < NV; i++) begin
      p_yes[i] = y[i];
      p_no[i] = n[i];
    end
  endtask

  initial begin
    int n_edges;
    logic [NV-1:0] ry, rn, mv;
    logic rs, ra;

    // Voter 0 holds yes and later tries no, voter 1 presses both keys and
    // retries, voters 2 and 3 vote together, then early close, a restart
    // and an abort.
    vecs[0]  = mk(1'b1, 1'b0, 4'b0000, 4'b0000, 2'd1, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 4'b0001, 4'b0000, 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 4'b0001, 4'b0000, 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 4'b0001, 4'b0000, 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 4'b0001, 4'b0000, 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 4'b0001, 4'b0000, 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 4'b0000, 4'b0001, 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 4'b0010, 4'b0010, 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 4'b0000, 4'b0010, 2'd1, 4'd1, 4'd1, 4'b0011, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 4'b1100, 4'b0000, 2'd1, 4'd3, 4'd1, 4'b1111, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 4'b1100, 4'b0000, 2'd2, 4'd3, 4'd1, 4'b1111, 1'b1, 1'b1);
    vecs[13] = mk(1'b1, 1'b0, 4'b1100, 4'b0000, 2'd1, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);

    do_reset();
    #1;
    check_output("reset", 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].s, vecs[i].a, vecs[i].y, vecs[i].n);
      check_output($sformatf("vec%0d", i), vecs[i].st, vecs[i].ag, vecs[i].dg,
                   vecs[i].vt, vecs[i].rv, vecs[i].ps);
    end

    // Timed close: votes in separate cycles, RESULT exactly WIN edges after
    // the start edge.
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    check_val("timed start state", 32'(state), 32'd1);
    n_edges = 0;
    for (int n = 1; n <= 40; n++) begin
      ry = (n == 2) ? 4'b0001 : (n == 4) ? 4'b0010 : 4'b0000;
      rn = (n == 6) ? 4'b0100 : 4'b0000;
      apply_stimulus(1'b0, 1'b0, ry, rn);
      n_edges = n;
      if (state == 2'd2) break;
    end
    check_val("timed close edges", 32'(n_edges), 32'(WIN));
    check_output("timed close", 2'd2, 4'd2, 4'd1, 4'b0111, 1'b1, 1'b1);

    // A vote on the expiry edge still counts.
    apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int n = 1; n < WIN; n++) apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_val("pre expiry state", 32'(state), 32'd1);
    apply_stimulus(1'b0, 1'b0, 4'b1000, 4'b0000);
    check_output("expiry vote", 2'd2, 4'd1, 4'd0, 4'b1000, 1'b1, 1'b1);

    // Abort coinciding with a yes event and timer expiry.
    apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int n = 1; n < WIN; n++) apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    apply_stimulus(1'b0, 1'b1, 4'b0001, 4'b0000);
    check_output("abort at expiry", 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);

    // Tie gives passed=0; a start from RESULT clears everything.
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    apply_stimulus(1'b0, 1'b0, 4'b0011, 4'b1100);
    check_output("tie votes", 2'd1, 4'd2, 4'd2, 4'b1111, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_output("tie result", 2'd2, 4'd2, 4'd2, 4'b1111, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    check_output("restart", 2'd1, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);

    // All voters at once, early close, then abort beats start in RESULT.
    apply_stimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
    check_output("all yes", 2'd1, 4'd4, 4'd0, 4'b1111, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_output("early close", 2'd2, 4'd4, 4'd0, 4'b1111, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    check_output("abort beats start", 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a session, between edges.
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    apply_stimulus(1'b0, 1'b0, 4'b0001, 4'b0000);
    check_output("pre reset", 2'd1, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset", 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random stimulus against the reference model. Start and abort are
    // never driven high together, so their events never coincide.
    do_reset();
    model_init();
    for (int c = 0; c < 1500; c++) begin
      ra = ($urandom_range(0, 15) == 0);
      rs = ra ? 1'b0 : ($urandom_range(0, 3) == 0);
      ry = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      rn = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      apply_stimulus(rs, ra, ry, rn);
      model_edge(rs, ra, ry, rn);
      for (int i = 0; i < NV; i++) mv[i] = m_voted[i];
      check_output($sformatf("rand%0d", c), 2'(m_phase), 4'(m_agree), 4'(m_disagree),
                   mv, (m_phase == 2), (m_phase == 2) && (m_agree > m_disagree));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
